npc_pc_unit: RTL and testbench

Stateful fetch-address unit for the pipelined MIPS core. It is the successor to the combinational next-PC selector.
- Owns the F-stage PC register and resolves control transfers for the instruction in D: branches, j/jal/jr/jalr, eret.
- Applies CP0 exception redirects and stalls, produces the D-stage link address, and tracks branch-delay-slot status.
- Flags illegal fetch addresses.

---
 rtl/npc_pc_unit.sv | 178 +++++++++++++++++
 tb/tb_npc_pc_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/npc_pc_unit.sv
// ---------------------------------------------------------------------------
// npc_pc_unit
//
// Fetch-address unit for the pipelined MIPS core. Holds the F-stage PC
// register, resolves control transfers for the instruction sitting in D
// (conditional branches, j/jal/jr/jalr, eret), applies CP0 exception
// redirects and hazard stalls, produces the D-stage link address and keeps
// track of whether the instruction now in D is a branch delay slot.
//
// Ports
//   clk          core clock
//   reset        synchronous, active-high reset
//   stall        hazard stall, hold F and D
//   D_instr      instruction currently in D
//   D_pc         PC of D_instr
//   D_cmp_taken  branch condition result from the D comparator
//   D_rs_val     forwarded rs value, the jr/jalr target
//   EPC          CP0 exception return address
//   exc_req      CP0 exception/interrupt entry request
//   F_pc         current fetch address (registered)
//   D_pc8        D_pc + 8, link value for jal/jalr
//   D_bd         instruction in D sits in a branch delay slot (registered)
//   F_flush      kill the F instruction on the next edge (eret)
//   F_adel       current fetch address is misaligned or out of range
// ---------------------------------------------------------------------------
module npc_pc_unit #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter logic [31:0] ADDR_LO  = 32'h0000_3000,
    parameter logic [31:0] ADDR_HI  = 32'h0000_4FFC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [31:0]       D_instr,
    input  logic [ADDR_W-1:0] D_pc,
    input  logic              D_cmp_taken,
    input  logic [ADDR_W-1:0] D_rs_val,
    input  logic [ADDR_W-1:0] EPC,
    input  logic              exc_req,
    output logic [ADDR_W-1:0] F_pc,
    output logic [ADDR_W-1:0] D_pc8,
    output logic              D_bd,
    output logic              F_flush,
    output logic              F_adel
);

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LINK_OFS = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] RST_PC   = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_PC   = EXC_VEC[ADDR_W-1:0];
    localparam logic [31:0]       ERET_WORD = 32'h4200_0018;

    // MIPS opcode / funct values recognised in D
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              bd_q;
    logic              bd_d;

    logic [5:0]        opcode;
    logic [4:0]        rtField;
    logic [5:0]        funct;
    logic [15:0]       imm;

    logic              isBranch;
    logic              isJump;
    logic              isJumpReg;
    logic              isEret;
    logic              isJb;

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] brOffset;
    logic [ADDR_W-1:0] brTarget;
    logic [ADDR_W-1:0] jTarget;

    assign opcode  = D_instr[31:26];
    assign rtField = D_instr[20:16];
    assign funct   = D_instr[5:0];
    assign imm     = D_instr[15:0];

    // Instruction classification of the word in D. bltz/bgez share the
    // REGIMM opcode and are told apart by rt; any other rt is not a branch.
    always_comb begin
        isBranch  = 1'b0;
        isJump    = 1'b0;
        isJumpReg = 1'b0;
        case (opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: isBranch = 1'b1;
            OP_REGIMM: isBranch = (rtField == RT_BLTZ) || (rtField == RT_BGEZ);
            OP_J, OP_JAL: isJump = 1'b1;
            OP_SPECIAL: isJumpReg = (funct == FN_JR) || (funct == FN_JALR);
            default: ;
        endcase
    end

    assign isEret = (D_instr == ERET_WORD);
    assign isJb   = isBranch | isJump | isJumpReg;

    // Target arithmetic, all modulo 2^ADDR_W. The branch offset is the
    // 16-bit immediate shifted by two and sign-extended to ADDR_W bits.
    assign pc4      = D_pc + PC_STEP;
    assign brOffset = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
    assign brTarget = pc4 + brOffset;

    // The j/jal region bits come from pc4 above bit 28; with a 28-bit PC
    // there is no region field and the index alone fills the address.
    generate
        if (ADDR_W > 28) begin : gRegion
            assign jTarget = {pc4[ADDR_W-1:28], D_instr[25:0], 2'b00};
        end else begin : gNoRegion
            assign jTarget = {D_instr[25:0], 2'b00};
        end
    endgenerate

    // Next-state selection. Exception entry beats stall; a stalled jump is
    // simply re-evaluated on the first unstalled cycle because D still holds
    // it. eret redirects without a delay slot, so D_bd drops with it.
    always_comb begin
        pc_d = pc_q + PC_STEP;
        bd_d = bd_q;
        if (exc_req) begin
            pc_d = EXC_PC;
            bd_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
            bd_d = bd_q;
        end else begin
            bd_d = isJb;
            if (isEret) begin
                pc_d = EPC;
            end else if (isBranch && D_cmp_taken) begin
                pc_d = brTarget;
            end else if (isJump) begin
                pc_d = jTarget;
            end else if (isJumpReg) begin
                pc_d = D_rs_val;
            end
        end
    end

    // PC and delay-slot registers. Reset overrides everything, including any
    // redirect that was decided in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RST_PC;
            bd_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            bd_q <= bd_d;
        end
    end

    assign F_pc    = pc_q;
    assign D_bd    = bd_q;
    assign D_pc8   = D_pc + LINK_OFS;
    assign F_flush = isEret & ~stall & ~exc_req;

    // Fault flag only; the PC itself is never corrected. Range compare is
    // done at 32 bits so narrower PCs compare against the full limits.
    assign F_adel = (pc_q[1:0] != 2'b00) ||
                    (32'(pc_q) < ADDR_LO) ||
                    (32'(pc_q) > ADDR_HI);

endmodule

// File: tb/tb_npc_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_npc_pc_unit
//
// Self-checking bench for npc_pc_unit. Each cycle's stimulus is driven on
// the falling edge together with the expected post-edge PC/D_bd, which is
// queued and then compared once the rising edge has taken effect.
// ---------------------------------------------------------------------------
module tb_npc_pc_unit;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] ERET  = 32'h4200_0018;
    localparam logic [31:0] EPCV  = 32'h0000_3040;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        bd;
    } expT;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] dInstr;
    logic [31:0] dPc;
    logic        dCmpTaken;
    logic [31:0] dRsVal;
    logic [31:0] epc;
    logic        excReq;
    logic [31:0] fPc;
    logic [31:0] dPc8;
    logic        dBd;
    logic        fFlush;
    logic        fAdel;

    int  total = 0;
    int  bad   = 0;
    expT sbQueue[$];

    npc_pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .D_instr     (dInstr),
        .D_pc        (dPc),
        .D_cmp_taken (dCmpTaken),
        .D_rs_val    (dRsVal),
        .EPC         (epc),
        .exc_req     (excReq),
        .F_pc        (fPc),
        .D_pc8       (dPc8),
        .D_bd        (dBd),
        .F_flush     (fFlush),
        .F_adel      (fAdel)
    );

    // 10 ns core clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Illegal-fetch rule: misaligned or outside 0x3000..0x4FFC
    function automatic logic adelOf(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_4FFC);
    endfunction

    // One cycle: drive on the falling edge, check combinational outputs while
    // the inputs settle, queue the expected registered state, then pop and
    // compare it just after the rising edge.
    task automatic applyStimulus(
        input string       tag,
        input logic        rst,
        input logic        stl,
        input logic        exc,
        input logic [31:0] instr,
        input logic [31:0] pcD,
        input logic        cmp,
        input logic [31:0] rs,
        input logic [31:0] expPc,
        input logic        expBd
    );
        expT e;
        @(negedge clk);
        reset     = rst;
        stall     = stl;
        excReq    = exc;
        dInstr    = instr;
        dPc       = pcD;
        dCmpTaken = cmp;
        dRsVal    = rs;
        epc       = EPCV;
        #1;
        checkOutput({tag, ".pc8"},   dPc8, pcD + 32'd8);
        checkOutput({tag, ".flush"}, {31'd0, fFlush},
                    {31'd0, (instr == ERET) && !stl && !exc && !rst});
        e.tag = tag;
        e.pc  = expPc;
        e.bd  = expBd;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        e = sbQueue.pop_front();
        checkOutput({e.tag, ".pc"},   fPc, e.pc);
        checkOutput({e.tag, ".bd"},   {31'd0, dBd}, {31'd0, e.bd});
        checkOutput({e.tag, ".adel"}, {31'd0, fAdel}, {31'd0, adelOf(e.pc)});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; excReq = 1'b0; dInstr = NOP;
        dPc = 32'h0; dCmpTaken = 1'b0; dRsVal = 32'h0; epc = EPCV;

        // Reset and free-running fetch
        applyStimulus("rst0",  1, 0, 0, NOP, 32'h3000, 0, 0, 32'h3000, 0);
        applyStimulus("rst1",  1, 0, 0, NOP, 32'h3000, 0, 0, 32'h3000, 0);
        applyStimulus("seq1",  0, 0, 0, NOP, 32'h3000, 0, 0, 32'h3004, 0);
        applyStimulus("seq2",  0, 0, 0, NOP, 32'h3000, 0, 0, 32'h3008, 0);
        applyStimulus("seq3",  0, 0, 0, NOP, 32'h3004, 0, 0, 32'h300C, 0);

        // Branches taken / not taken
        applyStimulus("beqT",  0, 0, 0, 32'h1000_0003, 32'h3008, 1, 0, 32'h3018, 1);
        applyStimulus("bneN",  0, 0, 0, 32'h1400_FFFF, 32'h300C, 0, 0, 32'h301C, 1);

        // jal, then jr to a misaligned target
        applyStimulus("jal",   0, 0, 0, 32'h0C00_0C10, 32'h300C, 0, 0, 32'h3040, 1);
        applyStimulus("jrMis", 0, 0, 0, 32'h0000_0008, 32'h3010, 0, 32'h3002, 32'h3002, 1);
        applyStimulus("nop1",  0, 0, 0, NOP, 32'h3014, 0, 0, 32'h3006, 0);

        // Stall holding a j in D, then release
        applyStimulus("stl1",  0, 1, 0, 32'h0800_0C20, 32'h3010, 0, 0, 32'h3006, 0);
        applyStimulus("stl2",  0, 1, 0, 32'h0800_0C20, 32'h3010, 0, 0, 32'h3006, 0);
        applyStimulus("jRel",  0, 0, 0, 32'h0800_0C20, 32'h3010, 0, 0, 32'h3080, 1);

        // Exception beats stall and eret
        applyStimulus("excSt", 0, 1, 1, ERET, 32'h3084, 0, 0, 32'h4180, 0);
        applyStimulus("bneN2", 0, 0, 0, 32'h1400_0004, 32'h4180, 0, 0, 32'h4184, 1);

        // eret redirect, then reset with a pending jump and a stall
        applyStimulus("eret",  0, 0, 0, ERET, 32'h4184, 0, 0, 32'h3040, 0);
        applyStimulus("rstJ",  1, 1, 0, 32'h0800_0C20, 32'h3040, 0, 0, 32'h3000, 0);

        // Remaining branch and jump forms
        applyStimulus("bltzT", 0, 0, 0, 32'h0400_FFFE, 32'h3100, 1, 0, 32'h30FC, 1);
        applyStimulus("bgezT", 0, 0, 0, 32'h0401_0004, 32'h3100, 1, 0, 32'h3114, 1);
        applyStimulus("blezT", 0, 0, 0, 32'h1800_0001, 32'h3200, 1, 0, 32'h3208, 1);
        applyStimulus("bgtzN", 0, 0, 0, 32'h1C00_0010, 32'h3204, 0, 0, 32'h320C, 1);
        applyStimulus("rimm2", 0, 0, 0, 32'h0402_0040, 32'h3208, 1, 0, 32'h3210, 0);
        applyStimulus("jalr",  0, 0, 0, 32'h0000_0009, 32'h3300, 0, 32'h3500, 32'h3500, 1);

        // Upper range boundary and wrap
        applyStimulus("jrHi",  0, 0, 0, 32'h0000_0008, 32'h3500, 0, 32'h4FFC, 32'h4FFC, 1);
        applyStimulus("pastHi",0, 0, 0, NOP, 32'h3504, 0, 0, 32'h5000, 0);
        applyStimulus("jrTop", 0, 0, 0, 32'h0000_0008, 32'h5000, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1);
        applyStimulus("wrap",  0, 0, 0, NOP, 32'h5004, 0, 0, 32'h0000_0000, 0);
        applyStimulus("wrap4", 0, 0, 0, NOP, 32'h5008, 0, 0, 32'h0000_0004, 0);

        // Exception without stall, eret in D
        applyStimulus("excEr", 0, 0, 1, ERET, 32'h3000, 0, 0, 32'h4180, 0);

        checkOutput("sbEmpty", sbQueue.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
